// File: rtl/ddma_send_packetizer.sv
// Send-side DMA packetizer: prefetches payload words into a 2-entry FIFO and emits header/size/payload flits.
// Optional DDMA_SEND_CHECKSUM_EN appends an XOR trailer flit after the payload.
module ddma_send_packetizer #(
  parameter int MEMORY_BUS_WIDTH = 32,
  parameter int FLIT_WIDTH       = 32,
  parameter int ADDRESS          = 0
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [MEMORY_BUS_WIDTH-1:0] send_addr_in,
  input  logic [MEMORY_BUS_WIDTH-1:0] send_size_in,
  input  logic [MEMORY_BUS_WIDTH-1:0] send_dest_in,
  input  logic                        send_cmd_in,
  output logic [7:0]                  state_send_out,
  output logic                        irq_send_out,
  output logic                        mem_en_out,
  output logic [MEMORY_BUS_WIDTH-1:0] mem_addr_out,
  input  logic [MEMORY_BUS_WIDTH-1:0] mem_data_in,
  output logic [FLIT_WIDTH-1:0]       tx_data_out,
  output logic                        tx_valid_out,
  input  logic                        tx_ack_in
);

  localparam int W = MEMORY_BUS_WIDTH;
  localparam logic [15:0] SRC_ID = 16'(ADDRESS);

  typedef enum logic [7:0] {
    S_IDLE    = 8'h00,
    S_HDR     = 8'h01,
    S_SIZE    = 8'h02,
    S_PAYLOAD = 8'h03,
`ifdef DDMA_SEND_CHECKSUM_EN
    S_TRAIL   = 8'h05,
`endif
    S_DONE    = 8'h04
  } state_t;

`ifdef DDMA_SEND_CHECKSUM_EN
  localparam state_t POST_PAYLOAD = S_TRAIL;
`else
  localparam state_t POST_PAYLOAD = S_DONE;
`endif

  state_t state, state_nxt;

  logic [W-1:0] addr_q, size_q, rd_cnt, sent_cnt;
  logic [15:0]  dest_q;
  logic [W-1:0] fifo_mem [2];
  logic         rd_ptr, wr_ptr, inflight;
  logic [1:0]   fifo_cnt;
`ifdef DDMA_SEND_CHECKSUM_EN
  logic [W-1:0] csum;
`endif

  logic       fetch_active, fifo_empty, start, pop, rd_issue, last_payload;
  logic [2:0] occupancy;
  logic       unused_dest_bits;

  assign unused_dest_bits = ^send_dest_in[W-1:16];

  // A pop on this edge frees a slot, so count it to keep one flit per cycle.
  always_comb begin
    fifo_empty   = (fifo_cnt == 2'd0);
    fetch_active = (state == S_HDR) || (state == S_SIZE) || (state == S_PAYLOAD);
    start        = (state == S_IDLE) && send_cmd_in;
    pop          = (state == S_PAYLOAD) && !fifo_empty && tx_ack_in;
    occupancy    = 3'(fifo_cnt) + 3'(inflight) - 3'(pop);
    rd_issue     = fetch_active && (rd_cnt != size_q) && (occupancy < 3'd2);
    last_payload = pop && ((sent_cnt + W'(1)) == size_q);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (send_cmd_in) state_nxt = S_HDR;
      S_HDR:     if (tx_ack_in) state_nxt = S_SIZE;
      S_SIZE:    if (tx_ack_in) state_nxt = (size_q == '0) ? POST_PAYLOAD : S_PAYLOAD;
      S_PAYLOAD: if (last_payload) state_nxt = POST_PAYLOAD;
`ifdef DDMA_SEND_CHECKSUM_EN
      S_TRAIL:   if (tx_ack_in) state_nxt = S_DONE;
`endif
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    state_send_out = state;
    irq_send_out   = (state == S_DONE);
    mem_en_out     = rd_issue;
    mem_addr_out   = rd_issue ? (addr_q + (rd_cnt << 2)) : '0;
    tx_valid_out   = 1'b0;
    tx_data_out    = '0;
    case (state)
      S_HDR: begin
        tx_valid_out = 1'b1;
        tx_data_out  = FLIT_WIDTH'({SRC_ID, dest_q});
      end
      S_SIZE: begin
        tx_valid_out = 1'b1;
        tx_data_out  = FLIT_WIDTH'(size_q);
      end
      S_PAYLOAD: begin
        tx_valid_out = !fifo_empty;
        tx_data_out  = fifo_empty ? '0 : FLIT_WIDTH'(fifo_mem[rd_ptr]);
      end
`ifdef DDMA_SEND_CHECKSUM_EN
      S_TRAIL: begin
        tx_valid_out = 1'b1;
        tx_data_out  = FLIT_WIDTH'(csum);
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_q      <= '0;
      size_q      <= '0;
      dest_q      <= '0;
      rd_cnt      <= '0;
      sent_cnt    <= '0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      fifo_cnt    <= 2'd0;
      inflight    <= 1'b0;
`ifdef DDMA_SEND_CHECKSUM_EN
      csum        <= '0;
`endif
    end else if (start) begin
      addr_q   <= send_addr_in;
      size_q   <= send_size_in;
      dest_q   <= send_dest_in[15:0];
      rd_cnt   <= '0;
      sent_cnt <= '0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
      inflight <= 1'b0;
`ifdef DDMA_SEND_CHECKSUM_EN
      csum     <= '0;
`endif
    end else begin
      inflight <= rd_issue;
      if (rd_issue) rd_cnt <= rd_cnt + W'(1);
      if (inflight) begin
        fifo_mem[wr_ptr] <= mem_data_in;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr   <= ~rd_ptr;
        sent_cnt <= sent_cnt + W'(1);
`ifdef DDMA_SEND_CHECKSUM_EN
        csum     <= csum ^ fifo_mem[rd_ptr];
`endif
      end
      fifo_cnt <= fifo_cnt + 2'(inflight) - 2'(pop);
    end
  end

endmodule

// File: tb/tb_ddma_send_packetizer.sv
// Directed self-checking bench for ddma_send_packetizer (ADDRESS=3), with a 1-cycle memory model and flit/read monitors.
module tb_ddma_send_packetizer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] send_addr_in = '0, send_size_in = '0, send_dest_in = '0;
  logic        send_cmd_in = 1'b0;
  logic [7:0]  state_send_out;
  logic        irq_send_out, mem_en_out, tx_valid_out;
  logic [31:0] mem_addr_out, tx_data_out;
  logic [31:0] mem_data_in = '0;
  logic        tx_ack_in = 1'b0;

  ddma_send_packetizer #(.MEMORY_BUS_WIDTH(32), .FLIT_WIDTH(32), .ADDRESS(3)) dut (
    .clock(clock), .reset(reset),
    .send_addr_in(send_addr_in), .send_size_in(send_size_in), .send_dest_in(send_dest_in),
    .send_cmd_in(send_cmd_in), .state_send_out(state_send_out), .irq_send_out(irq_send_out),
    .mem_en_out(mem_en_out), .mem_addr_out(mem_addr_out), .mem_data_in(mem_data_in),
    .tx_data_out(tx_data_out), .tx_valid_out(tx_valid_out), .tx_ack_in(tx_ack_in)
  );

  always #5 clock = ~clock;

`ifdef DDMA_SEND_CHECKSUM_EN
  localparam int TRL = 1;
`else
  localparam int TRL = 0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mem_words [8];
  logic [31:0] flit_log [$];
  logic [7:0]  flit_state [$];
  logic [31:0] rd_log [$];
  int          irq_cnt, pay_pops, rd_total, max_outst, unstable;
  logic        rd_req = 1'b0;
  logic [31:0] rd_data_nxt = '0;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_data = '0;

  // Memory model: data appears on the edge after the strobe cycle.
  always @(posedge clock) if (rd_req) mem_data_in <= rd_data_nxt;

  // Monitors sample 1 time unit after the falling edge, after the bench drives inputs.
  always begin
    @(negedge clock);
    #1;
    rd_req = mem_en_out;
    if (mem_en_out) begin
      rd_log.push_back(mem_addr_out);
      rd_data_nxt = mem_words[mem_addr_out[4:2]];
      rd_total++;
    end
    if (irq_send_out) irq_cnt++;
    if (tx_valid_out && tx_ack_in) begin
      flit_log.push_back(tx_data_out);
      flit_state.push_back(state_send_out);
      if (state_send_out == 8'h03) pay_pops++;
    end
    if (rd_total - pay_pops > max_outst) max_outst = rd_total - pay_pops;
    if (prev_hold && (!tx_valid_out || tx_data_out !== prev_data)) unstable++;
    prev_hold = reset && tx_valid_out && !tx_ack_in;
    prev_data = tx_data_out;
  end

  task automatic clear_logs();
    flit_log.delete(); flit_state.delete(); rd_log.delete();
    irq_cnt = 0; pay_pops = 0; rd_total = 0; max_outst = 0; unstable = 0;
  endtask

  // Issue a command and run until the FSM returns to IDLE; ack_mode 0 = held high, 1 = pattern 1,0,0.
  task automatic send_packet(input logic [31:0] addr, input logic [31:0] size, input logic [31:0] dest,
                             input int ack_mode, input bit poke, output int edges);
    int n;
    @(negedge clock);
    clear_logs();
    send_addr_in = addr; send_size_in = size; send_dest_in = dest;
    send_cmd_in = 1'b1;
    tx_ack_in = 1'b1;
    n = 0;
    edges = -1;
    while (n < 200) begin
      @(negedge clock);
      n++;
      send_cmd_in = 1'b0;
      if (poke && state_send_out == 8'h03 && pay_pops == 1) begin
        send_cmd_in = 1'b1;
        send_addr_in = 32'h0000_0700;
        poke = 1'b0;
      end
      tx_ack_in = (ack_mode == 0) ? 1'b1 : (n % 3 == 0);
      if (state_send_out == 8'h00) begin
        edges = n - 1;
        break;
      end
    end
    send_cmd_in = 1'b0;
    tx_ack_in = 1'b1;
    repeat (3) @(negedge clock);
    #2;
    n_cmp++;
    if (edges < 0) begin
      n_bad++;
      $display("FAIL packet_timeout: FSM did not return to IDLE within 200 cycles");
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clock);
    #2;
    n_cmp++;
    if ({state_send_out, irq_send_out, mem_en_out, tx_valid_out} !== 11'd0 ||
        mem_addr_out !== 32'd0 || tx_data_out !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: state=%h irq=%b en=%b valid=%b addr=%h data=%h, required all 0",
               state_send_out, irq_send_out, mem_en_out, tx_valid_out, mem_addr_out, tx_data_out);
    end
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_basic();
    logic [31:0] exp [$];
    logic [31:0] exp_rd [$];
    int edges;
    mem_words = '{32'hA, 32'hB, 32'hC, 32'hD, 32'h0, 32'h0, 32'h0, 32'h0};
    exp = '{32'h0003_0007, 32'h4, 32'hA, 32'hB, 32'hC, 32'hD};
    if (TRL == 1) exp.push_back(32'hA ^ 32'hB ^ 32'hC ^ 32'hD);
    exp_rd = '{32'h100, 32'h104, 32'h108, 32'h10C};
    send_packet(32'h100, 32'd4, 32'd7, 0, 1'b0, edges);
    n_cmp++;
    if (flit_log.size() != exp.size()) begin
      n_bad++;
      $display("FAIL basic_flit_count: got %0d, required %0d", flit_log.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < flit_log.size(); i++) begin
      n_cmp++;
      if (flit_log[i] !== exp[i]) begin
        n_bad++;
        $display("FAIL basic_flit[%0d]: got %h, required %h", i, flit_log[i], exp[i]);
      end
    end
    n_cmp++;
    if (rd_log != exp_rd) begin
      n_bad++;
      $display("FAIL basic_reads: got %0d reads %p, required %p", rd_log.size(), rd_log, exp_rd);
    end
    n_cmp++;
    if (irq_cnt != 1) begin
      n_bad++;
      $display("FAIL basic_irq: got %0d pulses, required 1", irq_cnt);
    end
    n_cmp++;
    if (edges != 7 + TRL) begin
      n_bad++;
      $display("FAIL basic_latency: IDLE after %0d edges, required %0d", edges, 7 + TRL);
    end
  endtask

  task automatic test_size_zero();
    logic [31:0] exp [$];
    int edges;
    exp = '{32'h0003_0002, 32'h0};
    if (TRL == 1) exp.push_back(32'h0);
    send_packet(32'h100, 32'd0, 32'd2, 0, 1'b0, edges);
    n_cmp++;
    if (flit_log != exp) begin
      n_bad++;
      $display("FAIL size0_flits: got %p, required %p", flit_log, exp);
    end
    n_cmp++;
    if (rd_total != 0) begin
      n_bad++;
      $display("FAIL size0_no_reads: got %0d mem_en cycles, required 0", rd_total);
    end
    n_cmp++;
    if (irq_cnt != 1 || edges != 3 + TRL) begin
      n_bad++;
      $display("FAIL size0_done: irq=%0d edges=%0d, required irq=1 edges=%0d", irq_cnt, edges, 3 + TRL);
    end
  endtask

  task automatic test_stall();
    logic [31:0] exp [$];
    int edges;
    mem_words = '{32'h11, 32'h12, 32'h13, 32'h14, 32'h15, 32'h0, 32'h0, 32'h0};
    exp = '{32'h0003_0005, 32'h5, 32'h11, 32'h12, 32'h13, 32'h14, 32'h15};
    if (TRL == 1) exp.push_back(32'h11 ^ 32'h12 ^ 32'h13 ^ 32'h14 ^ 32'h15);
    send_packet(32'h200, 32'd5, 32'd5, 1, 1'b0, edges);
    n_cmp++;
    if (flit_log != exp) begin
      n_bad++;
      $display("FAIL stall_flits: got %p, required %p", flit_log, exp);
    end
    n_cmp++;
    if (unstable != 0) begin
      n_bad++;
      $display("FAIL stall_hold: %0d unacked flits changed, required 0", unstable);
    end
    n_cmp++;
    if (max_outst > 2 || rd_total != 5) begin
      n_bad++;
      $display("FAIL stall_outstanding: max=%0d reads=%0d, required max<=2 reads=5", max_outst, rd_total);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp [$];
    logic [31:0] exp_rd [$];
    int edges;
    mem_words = '{32'h22, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h21};
    exp_rd = '{32'hFFFF_FFFC, 32'h0000_0000};
    exp = '{32'h0003_0001, 32'h2, 32'h21, 32'h22};
    if (TRL == 1) exp.push_back(32'h21 ^ 32'h22);
    send_packet(32'hFFFF_FFFC, 32'd2, 32'd1, 0, 1'b0, edges);
    n_cmp++;
    if (rd_log != exp_rd) begin
      n_bad++;
      $display("FAIL wrap_reads: got %p, required %p", rd_log, exp_rd);
    end
    n_cmp++;
    if (flit_log != exp) begin
      n_bad++;
      $display("FAIL wrap_flits: got %p, required %p", flit_log, exp);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp [$];
    int n;
    int edges;
    mem_words = '{32'h31, 32'h32, 32'h33, 32'h34, 32'h0, 32'h0, 32'h0, 32'h0};
    @(negedge clock);
    clear_logs();
    send_addr_in = 32'h0; send_size_in = 32'd4; send_dest_in = 32'd8;
    send_cmd_in = 1'b1; tx_ack_in = 1'b1;
    n = 0;
    while (n < 50 && pay_pops < 2) begin
      @(negedge clock);
      send_cmd_in = 1'b0;
      #2;
      n++;
    end
    @(negedge clock);
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({state_send_out, irq_send_out, mem_en_out, tx_valid_out} !== 11'd0 ||
        mem_addr_out !== 32'd0 || tx_data_out !== 32'd0 || n >= 50) begin
      n_bad++;
      $display("FAIL midreset_outputs: state=%h en=%b valid=%b addr=%h data=%h loops=%0d, required all 0",
               state_send_out, mem_en_out, tx_valid_out, mem_addr_out, tx_data_out, n);
    end
    @(negedge clock);
    reset = 1'b1;
    mem_words = '{32'h55, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    exp = '{32'h0003_0009, 32'h1, 32'h55};
    if (TRL == 1) exp.push_back(32'h55);
    send_packet(32'h300, 32'd1, 32'd9, 0, 1'b0, edges);
    n_cmp++;
    if (flit_log != exp || irq_cnt != 1) begin
      n_bad++;
      $display("FAIL midreset_next_packet: got %p irq=%0d, required %p irq=1", flit_log, irq_cnt, exp);
    end
  endtask

  task automatic test_cmd_ignored();
    logic [31:0] exp [$];
    int edges;
    mem_words = '{32'h1, 32'h2, 32'h4, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    exp = '{32'h0003_0006, 32'h3, 32'h1, 32'h2, 32'h4};
    if (TRL == 1) exp.push_back(32'h7);
    send_packet(32'h0, 32'd3, 32'd6, 0, 1'b1, edges);
    n_cmp++;
    if (flit_log != exp) begin
      n_bad++;
      $display("FAIL ignore_flits: got %p, required %p", flit_log, exp);
    end
    n_cmp++;
    if (irq_cnt != 1 || state_send_out !== 8'h00) begin
      n_bad++;
      $display("FAIL ignore_irq: irq=%0d state=%h, required irq=1 state=00", irq_cnt, state_send_out);
    end
    if (TRL == 1 && flit_state.size() > 0) begin
      n_cmp++;
      if (flit_state[flit_state.size()-1] !== 8'h05) begin
        n_bad++;
        $display("FAIL trail_state: got %h, required 05", flit_state[flit_state.size()-1]);
      end
    end
  endtask

  initial begin
    clear_logs();
    mem_words = '{default: 32'h0};
    test_reset();
    test_basic();
    test_size_zero();
    test_stall();
    test_wrap();
    test_reset_mid();
    test_cmd_ignored();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ddma_send_packetizer.md
# ddma_send_packetizer

Send-side engine of the distributed DMA. It accepts a send command (`addr`, `size`, `dest`) from the controller, reads the payload from local memory through a 1-cycle-latency read port, and emits a packet of flits into the router local port using a valid/ack handshake. It signals completion with `irq_send_out` and reports progress on `state_send_out`.

## Interface
Parameters:
- `MEMORY_BUS_WIDTH`, 32, width of memory data, addresses and command fields.
- `FLIT_WIDTH`, 32, router flit width; must equal `MEMORY_BUS_WIDTH`.
- `ADDRESS`, 0, this node's NoC address; the low 16 bits are used as the source field.

Ports (one clock; `reset` is asynchronous and active-low):
- `clock` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `send_addr_in` in `MEMORY_BUS_WIDTH`: payload byte start address.
- `send_size_in` in `MEMORY_BUS_WIDTH`: payload length in words.
- `send_dest_in` in `MEMORY_BUS_WIDTH`: destination node; low 16 bits are used.
- `send_cmd_in` in 1: start request, sampled in IDLE only.
- `state_send_out` out 8: FSM state code.
- `irq_send_out` out 1: one-cycle completion pulse.
- `mem_en_out` out 1: memory read strobe.
- `mem_addr_out` out `MEMORY_BUS_WIDTH`: memory read byte address.
- `mem_data_in` in `MEMORY_BUS_WIDTH`: read data, valid one cycle after `mem_en_out`.
- `tx_data_out` out `FLIT_WIDTH`: flit to router.
- `tx_valid_out` out 1: flit valid.
- `tx_ack_in` in 1: router accepts the flit on the rising edge where `tx_valid_out && tx_ack_in`.

## Operation
- FSM states and `state_send_out` codes:
  - IDLE 0x00
  - HDR 0x01
  - SIZE 0x02
  - PAYLOAD 0x03
  - TRAIL 0x05 (only with the macro)
  - DONE 0x04
- IDLE: when `send_cmd_in`=1, latch `addr`, `size` and `dest`, clear the read and sent counters, and go to HDR. In all other states `send_cmd_in` is ignored; it is not queued.
- HDR: the header flit is {`ADDRESS[15:0]`, `send_dest_in[15:0]`}. On transfer, go to SIZE.
- SIZE: the flit is the latched size. On transfer, go to PAYLOAD; if size is 0, go to DONE (or TRAIL with the macro).
- PAYLOAD:
  - Flits come from a 2-entry FIFO of prefetched words.
  - `tx_valid_out` equals FIFO not empty.
  - After the last payload transfer, go to DONE (or TRAIL with the macro).
- Prefetch runs in HDR, SIZE and PAYLOAD.
  - Issue `mem_en_out` when reads remaining > 0 and FIFO count + in-flight read < 2.
  - `mem_addr_out` = latched addr + 4·reads issued, using modulo-2^`MEMORY_BUS_WIDTH` wrap.
  - Returning data is pushed into the FIFO.
- DONE: `irq_send_out`=1 for exactly this cycle, then go to IDLE.
- `tx_data_out` is held stable while `tx_valid_out`=1 and `tx_ack_in`=0.
- Reset at any time, including mid-packet:
  - All outputs go to 0.
  - The FSM goes to IDLE, the FIFO and counters clear, and any in-flight read is discarded.

## Timing
- Command sampled at edge E0 → header valid in the cycle after E0.
- With `tx_ack_in` held high, one flit transfers per edge: header E1, size E2, payload words E3…E(2+size).
- DONE lasts one cycle after the last transfer; IDLE follows, and a new command is accepted at the next edge.
- Total with continuous ack: size+3 cycles from command to IDLE (+1 with the macro).
- The FIFO sustains one payload flit per cycle under continuous ack, and it never overflows under arbitrary ack stalls.
- A simultaneous FIFO push and pop keeps the count unchanged.

## Configuration
- `DDMA_SEND_CHECKSUM_EN` defined: after the payload, emit one TRAIL flit. It is the XOR of all payload words, or 0 when size=0. The FSM then goes to DONE.
- Undefined: no TRAIL state, packet = header + size + payload, and the 0x05 code is never produced.

## Test plan
- `ADDRESS`=3, cmd addr=0x100, size=4, dest=7, memory words 0xA,0xB,0xC,0xD, ack held high:
  - flits 0x0003_0007, 0x4, 0xA, 0xB, 0xC, 0xD on consecutive edges;
  - reads at 0x100/104/108/10C;
  - `irq_send_out` pulses once; IDLE 7 cycles after the command.
- size=0, dest=2: flits 0x0003_0002 then 0x0 → DONE → irq; no `mem_en_out` ever asserted.
- size=5 with ack toggling 1,0,0,1…:
  - flit order and values are unchanged, and each flit is held stable while unacked;
  - at most 2 reads are outstanding or buffered at any time.
- Command with addr=0xFFFF_FFFC, size=2: reads at 0xFFFF_FFFC, then 0x0000_0000.
- Reset asserted during PAYLOAD, 2 words sent: all outputs 0 immediately. After release, a new command (size=1) produces a correct 3-flit packet with no stale data.
- `send_cmd_in` pulsed during PAYLOAD: ignored; exactly one irq. With `DDMA_SEND_CHECKSUM_EN` and payload 0x1,0x2,0x4: trailer 0x7 and `state_send_out`=0x05 during it.
